// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int DEF_STEP       = 4;
  localparam int DEF_ADDR_SHIFT = 2;

endpackage

// File: rtl/next_pc_sel.sv
// Fixed-priority next fetch address mux: boot, mispredict, jump, stall, BTB, sequential.
// Purely combinational; the stall leg re-reads pc so memory data stays stable.
module next_pc_sel #(
  parameter int WIDTH = 31,
  parameter int STEP  = fetch_pkg::DEF_STEP
) (
  input  logic             boot,
  input  logic [WIDTH:0]   pc,
  input  logic             stall,
  input  logic             mispredict,
  input  logic [WIDTH:0]   correctPC,
  input  logic             jumpValid,
  input  logic [WIDTH:0]   jumpPC,
  input  logic             btbHit,
  input  logic [WIDTH:0]   btbTarget,
  output logic [WIDTH:0]   nextPC
);

  always_comb begin
    nextPC = pc + (WIDTH+1)'(STEP);
    if (boot)            nextPC = pc;
    else if (mispredict) nextPC = correctPC;
    else if (jumpValid)  nextPC = jumpPC;
    else if (stall)      nextPC = pc;
    else if (btbHit)     nextPC = btbTarget;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, drives synchronous-read imem, one-cycle read latency, zero-bubble redirects.
// Stall holds every output by re-reading the current pc; redirects override stall and kill the current packet.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          WIDTH      = 31,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          STEP       = DEF_STEP,
  parameter int          ADDR_SHIFT = DEF_ADDR_SHIFT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           mispredict,
  input  logic [WIDTH:0] correctPC,
  input  logic           jumpValid,
  input  logic [WIDTH:0] jumpPC,
  input  logic           btbHit,
  input  logic [WIDTH:0] btbTarget,
  output logic [WIDTH:0] rAddress,
  input  logic [WIDTH:0] instr,
  output logic           fetchValid,
  output logic [WIDTH:0] fetchInstr,
  output logic [WIDTH:0] fetchPC,
  output logic [WIDTH:0] fetchSeqPC,
  output logic           fetchPredTaken
);

  fetch_state_t   state, state_next;
  logic [WIDTH:0] pc, nextPC;
  logic           validReg, valid_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= (WIDTH+1)'(RESET_PC);
      validReg <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= nextPC;
      validReg <= valid_next;
    end
  end

  // BOOT lasts exactly one cycle; the packet becomes valid on the edge leaving it.
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    case (state)
      BOOT: begin
        state_next = RUN;
        valid_next = 1'b1;
      end
      RUN: begin
        state_next = RUN;
        valid_next = 1'b1;
      end
      default: begin
        state_next = BOOT;
        valid_next = 1'b0;
      end
    endcase
  end

  next_pc_sel #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next_pc_sel (
    .boot       (state == BOOT),
    .pc         (pc),
    .stall      (stall),
    .mispredict (mispredict),
    .correctPC  (correctPC),
    .jumpValid  (jumpValid),
    .jumpPC     (jumpPC),
    .btbHit     (btbHit),
    .btbTarget  (btbTarget),
    .nextPC     (nextPC)
  );

  assign rAddress       = nextPC >> ADDR_SHIFT;
  assign fetchInstr     = instr;
  assign fetchPC        = pc;
  assign fetchSeqPC     = pc + (WIDTH+1)'(STEP);
  assign fetchValid     = validReg & ~mispredict & ~jumpValid;
  assign fetchPredTaken = btbHit & (state == RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous-read instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, mispredict, jumpValid, btbHit;
  logic [31:0] correctPC, jumpPC, btbTarget;
  logic [31:0] rAddress, instr, fetchInstr, fetchPC, fetchSeqPC;
  logic        fetchValid, fetchPredTaken;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  always #5 clk = ~clk;

  // Memory word at index i holds TAG ^ i, read data one cycle after address.
  always_ff @(posedge clk) instr <= rAddress ^ TAG;

  fetch_unit #(
    .WIDTH(31), .RESET_PC(32'h0), .STEP(4), .ADDR_SHIFT(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .mispredict     (mispredict),
    .correctPC      (correctPC),
    .jumpValid      (jumpValid),
    .jumpPC         (jumpPC),
    .btbHit         (btbHit),
    .btbTarget      (btbTarget),
    .rAddress       (rAddress),
    .instr          (instr),
    .fetchValid     (fetchValid),
    .fetchInstr     (fetchInstr),
    .fetchPC        (fetchPC),
    .fetchSeqPC     (fetchSeqPC),
    .fetchPredTaken (fetchPredTaken)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then leave a margin before driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; mispredict = 1'b0; jumpValid = 1'b0; btbHit = 1'b0;
    correctPC = '0; jumpPC = '0; btbTarget = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    btbHit = 1'b1;  // must not show as a prediction while in reset/BOOT
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid",    32'(fetchValid),     32'h0);
    check_val("rst_pc",       fetchPC,             32'h0);
    check_val("rst_seqpc",    fetchSeqPC,          32'h4);
    check_val("rst_pred",     32'(fetchPredTaken), 32'h0);
    check_val("rst_raddr",    rAddress,            32'h0);
    btbHit = 1'b0;

    reset = 1'b0;
    #1;
    check_val("boot_valid", 32'(fetchValid), 32'h0);
    check_val("boot_raddr", rAddress,        32'h0);

    // Sequential stream 0, 4, 8.
    step();
    check_val("seq0_valid", 32'(fetchValid), 32'h1);
    check_val("seq0_pc",    fetchPC,         32'h0);
    check_val("seq0_instr", fetchInstr,      TAG ^ 32'h0);
    check_val("seq0_raddr", rAddress,        32'h1);
    step();
    check_val("seq1_pc",    fetchPC,         32'h4);
    check_val("seq1_raddr", rAddress,        32'h2);
    check_val("seq1_instr", fetchInstr,      TAG ^ 32'h1);
    step();
    check_val("seq2_pc",    fetchPC,         32'h8);
    check_val("seq2_raddr", rAddress,        32'h3);

    // BTB hit at pc 0x8 redirects to 0x40.
    btbHit = 1'b1; btbTarget = 32'h40;
    #1;
    check_val("btb_pred",  32'(fetchPredTaken), 32'h1);
    check_val("btb_raddr", rAddress,            32'h10);
    step();
    clear_inputs();
    #1;
    check_val("btb_pc",    fetchPC,             32'h40);
    check_val("btb_instr", fetchInstr,          TAG ^ 32'h10);
    check_val("btb_pred0", 32'(fetchPredTaken), 32'h0);

    // Mispredict + jump + stall together: mispredict wins, packet killed.
    mispredict = 1'b1; correctPC = 32'h80;
    jumpValid = 1'b1; jumpPC = 32'h20; stall = 1'b1;
    #1;
    check_val("redir_valid", 32'(fetchValid), 32'h0);
    check_val("redir_raddr", rAddress,        32'h20);
    step();
    clear_inputs();
    #1;
    check_val("redir_pc",    fetchPC,         32'h80);
    check_val("redir_vld1",  32'(fetchValid), 32'h1);
    check_val("redir_instr", fetchInstr,      TAG ^ 32'h20);

    // Jump alone kills the packet and goes to 0x10.
    jumpValid = 1'b1; jumpPC = 32'h10;
    #1;
    check_val("jmp_valid", 32'(fetchValid), 32'h0);
    step();
    clear_inputs();
    #1;
    check_val("jmp_pc", fetchPC, 32'h10);

    // Three stalled cycles hold everything.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("stall%0d_pc", i),    fetchPC,         32'h10);
      check_val($sformatf("stall%0d_instr", i), fetchInstr,      TAG ^ 32'h4);
      check_val($sformatf("stall%0d_valid", i), 32'(fetchValid), 32'h1);
      check_val($sformatf("stall%0d_raddr", i), rAddress,        32'h4);
      step();
    end
    stall = 1'b0;
    #1;
    check_val("rel_pc",    fetchPC,    32'h10);
    check_val("rel_raddr", rAddress,   32'h5);
    step();
    check_val("rel_next",  fetchPC,    32'h14);
    check_val("rel_instr", fetchInstr, TAG ^ 32'h5);

    // Sequential wrap at the top of the address space.
    jumpValid = 1'b1; jumpPC = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    #1;
    check_val("wrap_pc",    fetchPC,    32'hFFFF_FFFC);
    check_val("wrap_seqpc", fetchSeqPC, 32'h0);
    check_val("wrap_raddr", rAddress,   32'h0);
    step();
    check_val("wrap_next",  fetchPC,    32'h0);

    // Move away from RESET_PC, then assert reset between edges.
    jumpValid = 1'b1; jumpPC = 32'h100;
    step();
    clear_inputs();
    #1;
    check_val("pre_rst_pc", fetchPC, 32'h100);
    btbHit = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(fetchValid),     32'h0);
    check_val("mid_rst_pc",    fetchPC,             32'h0);
    check_val("mid_rst_seqpc", fetchSeqPC,          32'h4);
    check_val("mid_rst_pred",  32'(fetchPredTaken), 32'h0);
    check_val("mid_rst_raddr", rAddress,            32'h0);
    btbHit = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check_val("reboot_valid", 32'(fetchValid), 32'h0);
    step();
    check_val("restart_valid", 32'(fetchValid), 32'h1);
    check_val("restart_pc",    fetchPC,         32'h0);
    check_val("restart_raddr", rAddress,        32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
